// File: rtl/div_hilo_seq.sv
// HI/LO sequencer around an external combinational signed divider: latches operands,
// waits DIV_LATENCY cycles, captures Q->LO and R->HI. Optional trap: DIV_ZERO_TRAP_EN.
module div_hilo_seq #(
  parameter int DIV_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] div_a,
  input  logic [31:0] div_m,
  output logic [31:0] op_a,
  output logic [31:0] op_m,
  input  logic [31:0] quo,
  input  logic [31:0] rem,
  input  logic        hi_wr_en,
  input  logic        lo_wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef DIV_ZERO_TRAP_EN
  logic div0_q;
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_m  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div0_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div0_q <= 1'b0;
`endif
      // NOTE: MTHI/MTLO are assigned first so the capture below, being the later
      // non-blocking assignment to the same register, takes priority on that edge.
      if (hi_wr_en) hi <= wr_data;
      if (lo_wr_en) lo <= wr_data;

      unique case (state)
        IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_TRAP_EN
            if (div_m == '0) begin
              div0_q <= 1'b1;
            end else begin
              op_a  <= div_a;
              op_m  <= div_m;
              cnt   <= CNT_LOAD;
              busy  <= 1'b1;
              state <= SETTLE;
            end
`else
            op_a  <= div_a;
            op_m  <= div_m;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
            state <= SETTLE;
`endif
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            hi    <= rem;
            lo    <= quo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_hilo_seq.sv
// Directed bench for div_hilo_seq; models the external combinational divider and
// checks latency, HI/LO capture, MTHI/MTLO priority, ignored starts and async clear.
module tb_div_hilo_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] div_a, div_m, op_a, op_m, quo, rem, wr_data, hi, lo;
  logic        hi_wr_en, lo_wr_en, busy, done, div0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  div_hilo_seq #(.DIV_LATENCY(4), .CNT_W(4)) dut (
    .clock(clock), .clear(clear), .start(start), .div_a(div_a), .div_m(div_m),
    .op_a(op_a), .op_m(op_m), .quo(quo), .rem(rem), .hi_wr_en(hi_wr_en),
    .lo_wr_en(lo_wr_en), .wr_data(wr_data), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div0(div0)
  );

  // External divider: truncating signed divide, all-ones on zero divisor, overflow wraps.
  always_comb begin
    quo = '1;
    rem = '1;
    if (op_m == 32'h0) begin
      quo = '1;
      rem = '1;
    end else if (op_a == 32'h8000_0000 && op_m == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = 32'h0;
    end else begin
      quo = $signed(op_a) / $signed(op_m);
      rem = $signed(op_a) % $signed(op_m);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a start, then count cycles busy stays high (bounded).
  task automatic run_div(input logic [31:0] a, input logic [31:0] m, output int bc);
    start = 1'b1; div_a = a; div_m = m;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      tick();
    end
  endtask

  int bc;

  initial begin
    clear = 1'b1; start = 1'b0; div_a = '0; div_m = '0;
    hi_wr_en = 1'b0; lo_wr_en = 1'b0; wr_data = '0;
    #12;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_opa", op_a, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_div0", {31'b0, div0}, 32'h0);
    clear = 1'b0;
    tick();

    // 1: 100 / 7
    run_div(32'd100, 32'd7, bc);
    check("t1_busy_cycles", bc, 32'd4);
    check("t1_done", {31'b0, done}, 32'h1);
    check("t1_lo", lo, 32'd14);
    check("t1_hi", hi, 32'd2);
    tick();
    check("t1_done_pulse", {31'b0, done}, 32'h0);

    // 2: -100 / 7, then back-to-back start on the done cycle: 100 / -7
    run_div(32'hFFFF_FF9C, 32'd7, bc);
    check("t2a_lo", lo, 32'hFFFF_FFF2);
    check("t2a_hi", hi, 32'hFFFF_FFFE);
    check("t2a_done", {31'b0, done}, 32'h1);
    run_div(32'd100, 32'hFFFF_FFF9, bc);
    check("t2b_busy_cycles", bc, 32'd4);
    check("t2b_lo", lo, 32'hFFFF_FFF2);
    check("t2b_hi", hi, 32'd2);
    tick();

    // 3: overflow case captured verbatim
    run_div(32'h8000_0000, 32'hFFFF_FFFF, bc);
    check("t3_lo", lo, 32'h8000_0000);
    check("t3_hi", hi, 32'h0);
    tick();

    // 4: zero divisor
`ifdef DIV_ZERO_TRAP_EN
    start = 1'b1; div_a = 32'd55; div_m = 32'd0;
    tick();
    start = 1'b0;
    check("t4_div0", {31'b0, div0}, 32'h1);
    check("t4_busy", {31'b0, busy}, 32'h0);
    check("t4_opa", op_a, 32'h8000_0000);
    tick();
    check("t4_div0_pulse", {31'b0, div0}, 32'h0);
    check("t4_done", {31'b0, done}, 32'h0);
    check("t4_lo", lo, 32'h8000_0000);
    check("t4_hi", hi, 32'h0);
`else
    run_div(32'd55, 32'd0, bc);
    check("t4_busy_cycles", bc, 32'd4);
    check("t4_done", {31'b0, done}, 32'h1);
    check("t4_lo", lo, 32'hFFFF_FFFF);
    check("t4_hi", hi, 32'hFFFF_FFFF);
    check("t4_div0", {31'b0, div0}, 32'h0);
    tick();
`endif

    // 5: start held during SETTLE and on capture edge is ignored; capture beats MTLO
    start = 1'b1; div_a = 32'd100; div_m = 32'd7;
    tick();
    div_a = 32'd9; div_m = 32'd3;
    tick();
    tick();
    check("t5_opa_stable", op_a, 32'd100);
    check("t5_opm_stable", op_m, 32'd7);
    tick();
    lo_wr_en = 1'b1; wr_data = 32'h55;
    tick();
    start = 1'b0; lo_wr_en = 1'b0;
    check("t5_lo_capture_wins", lo, 32'd14);
    check("t5_hi", hi, 32'd2);
    check("t5_done", {31'b0, done}, 32'h1);
    tick();
    check("t5_not_queued", {31'b0, busy}, 32'h0);
    check("t5_opa_after", op_a, 32'd100);
    lo_wr_en = 1'b1; wr_data = 32'h55;
    tick();
    lo_wr_en = 1'b0;
    check("t5_mtlo", lo, 32'h55);
    check("t5_hi_kept", hi, 32'd2);
    hi_wr_en = 1'b1; lo_wr_en = 1'b1; wr_data = 32'hA5A5_0001;
    tick();
    hi_wr_en = 1'b0; lo_wr_en = 1'b0;
    check("t5_both_hi", hi, 32'hA5A5_0001);
    check("t5_both_lo", lo, 32'hA5A5_0001);

    // 6: async clear in the second SETTLE cycle
    start = 1'b1; div_a = 32'd100; div_m = 32'd7;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    #1;
    check("t6_busy", {31'b0, busy}, 32'h0);
    check("t6_hi", hi, 32'h0);
    check("t6_lo", lo, 32'h0);
    check("t6_opa", op_a, 32'h0);
    check("t6_opm", op_m, 32'h0);
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_done", {31'b0, done}, 32'h0);
    end
    check("t6_lo_no_capture", lo, 32'h0);
    run_div(32'd9, 32'd3, bc);
    check("t6_idle_busy_cycles", bc, 32'd4);
    check("t6_idle_lo", lo, 32'd3);
    check("t6_idle_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
